name_line_compress: RTL and testbench
=====================================

Name: name_line_compress

Overview:
- Per-field delta compressor for FASTQ read-name lines.
- Each accepted line arrives as ten 16-byte ASCII fields. The block compares every field against the same field of the previously accepted line.
- Only changed fields are emitted, one cycle later, as 160-bit tagged records, each with its own write strobe.
- Sits between the name-line field splitter and the compressed-stream packer.

Parameters:
- SEQ_W, 16, width of the line sequence counter embedded in each record.
- REFRESH_PERIOD, 256, lines between forced full-line emissions. Used only with NLC_REFRESH_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- line_valid  in  1  current input fields form one name line; accepted this cycle.
- Inst_in, Run_in, Flow_in, Lane_in, Tile_in, Xpos_in, Ypos_r_in, Filtered_in, Cntl_num_in, Index_in  in  128 each  field text. Right-justified ASCII, unused high bytes 0x00.
- Inst_out … Index_out (same ten names, suffix _out)  out  160 each  field record.
- Inst_w … Index_w (same ten names, suffix _w)  out  1 each  record valid / field changed.

Behaviour:
- Fields are indexed by field id: Inst=0, Run=1, Flow=2, Lane=3, Tile=4, Xpos=5, Ypos_r=6, Filtered=7, Cntl_num=8, Index=9.
- Record format: [159:152] field id; [151:144] byte length; [143:128] line sequence number (low 16 bits of the counter); [127:0] field data unchanged.
- Byte length = 16 minus the count of leading 0x00 bytes from the MSB, range 0..16. An all-zero field has length 0.
- State:
  - prev[0..9]: 128 bits each.
  - first: 1 bit.
  - seq: SEQ_W bits.
- Reset (rst=1 at a clock edge): every *_out=0, every *_w=0, prev=0, first=1, seq=0.
- Accept (line_valid=1, rst=0): for each field f, changed_f = first OR (in_f != prev_f).
- Registered outputs, latency exactly 1 cycle after the accepting edge:
  - *_w_f = changed_f.
  - *_out_f = record if changed_f, else 0.
- Also on accept: prev_f is loaded with in_f for all f, first clears to 0, and seq increments (wrapping modulo 2^SEQ_W).
- The record carries the seq value before the increment, so the first line after reset is tagged 0.
- Comparison is always against the immediately preceding accepted line, never against an older reference.
- line_valid=0: all *_w=0 and all *_out=0 next cycle; prev, first and seq are held.
- Back-to-back lines are accepted every cycle with no stalls. There is no backpressure.
- rst has priority over line_valid. A line presented in a reset cycle is discarded.
- Reset mid-stream makes the next accepted line emit all ten fields, tagged seq 0.
- No X propagation: all state is reset.

Optional Feature:
- Macro NLC_REFRESH_EN.
- Defined:
  - A line whose seq before increment satisfies seq % REFRESH_PERIOD == 0 is treated as first.
  - All ten fields are emitted for that line.
  - This gives the decompressor periodic resync points.
- Undefined: only the first line after reset forces full emission. The refresh logic is absent.

Test Plan:
- Reset, then one line:
  - Stimulus: Inst="@HISEQ-MFG", Run="461", Flow="C70PYACXX", Lane="8", Tile="1101", Xpos="18260", Ypos_r="2391 1", Filtered="N", Cntl_num="0", Index="GCCAAT".
  - Next cycle: all ten *_w=1, seq 0.
  - Inst length 10, field id 0. Flow length 9. Index length 6.
- Same line again, but Inst="xxx":
  - Only Inst_w=1.
  - Inst_out = {8'h00, 8'h03, 16'h0001, "xxx"}.
  - All other *_out=0.
- Next line restores Inst="@HISEQ-MFG" and sets Run="xxx":
  - Inst_w=1 and Run_w=1 (Run length 3).
  - All other *_w=0.
- Single-field walk:
  - Stimulus: one field per line changed to "xxx" (Flow, then Lane, … , Cntl_num), the previous field restored.
  - Response: each line asserts exactly the changed field and the restored one, with correct ids and incrementing seq.
- All fields set to "0" except Cntl_num="9":
  - Stimulus comes after a line whose fields all differ from this one.
  - Response: all ten *_w=1. Each length is 1.
- Hold and reset:
  - line_valid=0 for 3 cycles: all *_w=0 and seq held.
  - Then rst pulsed one cycle mid-stream, then a line identical to the last: all ten *_w=1, seq 0.
  - With NLC_REFRESH_EN and REFRESH_PERIOD=4: the line tagged seq 4, identical to the prior line, still emits all ten fields.

Source files
------------

// File: rtl/name_line_compress_if.sv
// ---------------------------------------------------------------------------
// name_line_compress_if
//
// Purpose: bundles the name-line field bus between the field splitter
// (master), the per-field delta compressor (slave) and, on the output
// side, the compressed-stream packer.
//
// Signals:
//   line_valid          splitter -> compressor  fields below form one line
//   <Field>_in  [127:0] splitter -> compressor  right-justified ASCII text
//   <Field>_out [159:0] compressor -> packer    tagged field record
//   <Field>_w           compressor -> packer    record valid / field changed
// Fields: Inst, Run, Flow, Lane, Tile, Xpos, Ypos_r, Filtered, Cntl_num, Index
// ---------------------------------------------------------------------------
interface name_line_compress_if;
    logic         line_valid;

    logic [127:0] Inst_in;
    logic [127:0] Run_in;
    logic [127:0] Flow_in;
    logic [127:0] Lane_in;
    logic [127:0] Tile_in;
    logic [127:0] Xpos_in;
    logic [127:0] Ypos_r_in;
    logic [127:0] Filtered_in;
    logic [127:0] Cntl_num_in;
    logic [127:0] Index_in;

    logic [159:0] Inst_out;
    logic [159:0] Run_out;
    logic [159:0] Flow_out;
    logic [159:0] Lane_out;
    logic [159:0] Tile_out;
    logic [159:0] Xpos_out;
    logic [159:0] Ypos_r_out;
    logic [159:0] Filtered_out;
    logic [159:0] Cntl_num_out;
    logic [159:0] Index_out;

    logic         Inst_w;
    logic         Run_w;
    logic         Flow_w;
    logic         Lane_w;
    logic         Tile_w;
    logic         Xpos_w;
    logic         Ypos_r_w;
    logic         Filtered_w;
    logic         Cntl_num_w;
    logic         Index_w;

    modport master (
        output line_valid,
        output Inst_in, Run_in, Flow_in, Lane_in, Tile_in,
               Xpos_in, Ypos_r_in, Filtered_in, Cntl_num_in, Index_in,
        input  Inst_out, Run_out, Flow_out, Lane_out, Tile_out,
               Xpos_out, Ypos_r_out, Filtered_out, Cntl_num_out, Index_out,
        input  Inst_w, Run_w, Flow_w, Lane_w, Tile_w,
               Xpos_w, Ypos_r_w, Filtered_w, Cntl_num_w, Index_w
    );

    modport slave (
        input  line_valid,
        input  Inst_in, Run_in, Flow_in, Lane_in, Tile_in,
               Xpos_in, Ypos_r_in, Filtered_in, Cntl_num_in, Index_in,
        output Inst_out, Run_out, Flow_out, Lane_out, Tile_out,
               Xpos_out, Ypos_r_out, Filtered_out, Cntl_num_out, Index_out,
        output Inst_w, Run_w, Flow_w, Lane_w, Tile_w,
               Xpos_w, Ypos_r_w, Filtered_w, Cntl_num_w, Index_w
    );
endinterface

// File: rtl/name_line_compress.sv
// ---------------------------------------------------------------------------
// name_line_compress
//
// Purpose: per-field delta compressor for FASTQ read-name lines. Each
// accepted line carries ten 16-byte ASCII fields; every field is compared
// with the same field of the previously accepted line and only the changed
// fields are emitted, one cycle later, as 160-bit tagged records:
//   [159:152] field id   [151:144] byte length   [143:128] line seq   [127:0] data
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  name_line_compress_if.slave (line_valid, <Field>_in, <Field>_out, <Field>_w)
//
// Parameters:
//   SEQ_W           width of the line sequence counter
//   REFRESH_PERIOD  lines between forced full-line emissions (NLC_REFRESH_EN only)
//
// Build option: define NLC_REFRESH_EN to force a full-line emission whenever
// the line sequence number is a multiple of REFRESH_PERIOD.
// ---------------------------------------------------------------------------
module name_line_compress #(
    parameter int SEQ_W = 16
`ifdef NLC_REFRESH_EN
    ,
    parameter int REFRESH_PERIOD = 256
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    name_line_compress_if.slave  bus
);
    localparam int NF = 10;

    logic [127:0]     field_in [NF];
    logic [127:0]     prev     [NF];
    logic [159:0]     rec_d    [NF];
    logic [159:0]     rec_q    [NF];
    logic [NF-1:0]    changed;
    logic [NF-1:0]    w_q;
    logic             first;
    logic [SEQ_W-1:0] seq;
    logic [15:0]      seq_tag;
    logic             force_all;

    // Length = index of the most significant non-zero byte plus one; the
    // ascending scan leaves the highest hit in len.
    function automatic logic [7:0] byte_len(input logic [127:0] d);
        logic [7:0] len;
        len = 8'd0;
        for (int i = 0; i < 16; i++) begin
            if (d[i*8 +: 8] != 8'h00) len = 8'(i + 1);
        end
        return len;
    endfunction

    // Field order here defines the field id carried in each record.
    always_comb begin
        field_in[0] = bus.Inst_in;
        field_in[1] = bus.Run_in;
        field_in[2] = bus.Flow_in;
        field_in[3] = bus.Lane_in;
        field_in[4] = bus.Tile_in;
        field_in[5] = bus.Xpos_in;
        field_in[6] = bus.Ypos_r_in;
        field_in[7] = bus.Filtered_in;
        field_in[8] = bus.Cntl_num_in;
        field_in[9] = bus.Index_in;
    end

    // The record carries the pre-increment count, truncated or zero-extended
    // to the 16-bit tag slot.
    assign seq_tag = 16'(seq);

`ifdef NLC_REFRESH_EN
    assign force_all = first || ((32'(seq) % 32'(REFRESH_PERIOD)) == 32'd0);
`else
    assign force_all = first;
`endif

    // NOTE: every output of this block is assigned on every path through the
    // loop, so no latch can be inferred.
    always_comb begin
        for (int f = 0; f < NF; f++) begin
            changed[f] = force_all || (field_in[f] != prev[f]);
            rec_d[f]   = {8'(f), byte_len(field_in[f]), seq_tag, field_in[f]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from the same clock edge. The prev array is reset
    // too: it is ten words of flops, not a RAM, and a clean reset keeps X
    // out of the comparators.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NF; f++) begin
                prev[f]  <= '0;
                rec_q[f] <= '0;
            end
            w_q   <= '0;
            first <= 1'b1;
            seq   <= '0;
        end else if (bus.line_valid) begin
            for (int f = 0; f < NF; f++) begin
                rec_q[f] <= changed[f] ? rec_d[f] : '0;
                prev[f]  <= field_in[f];
            end
            w_q   <= changed;
            first <= 1'b0;
            seq   <= seq + 1'b1;
        end else begin
            // Idle cycle: outputs go quiet, prev/first/seq hold.
            for (int f = 0; f < NF; f++) begin
                rec_q[f] <= '0;
            end
            w_q <= '0;
        end
    end

    assign bus.Inst_out     = rec_q[0];
    assign bus.Run_out      = rec_q[1];
    assign bus.Flow_out     = rec_q[2];
    assign bus.Lane_out     = rec_q[3];
    assign bus.Tile_out     = rec_q[4];
    assign bus.Xpos_out     = rec_q[5];
    assign bus.Ypos_r_out   = rec_q[6];
    assign bus.Filtered_out = rec_q[7];
    assign bus.Cntl_num_out = rec_q[8];
    assign bus.Index_out    = rec_q[9];

    assign bus.Inst_w       = w_q[0];
    assign bus.Run_w        = w_q[1];
    assign bus.Flow_w       = w_q[2];
    assign bus.Lane_w       = w_q[3];
    assign bus.Tile_w       = w_q[4];
    assign bus.Xpos_w       = w_q[5];
    assign bus.Ypos_r_w     = w_q[6];
    assign bus.Filtered_w   = w_q[7];
    assign bus.Cntl_num_w   = w_q[8];
    assign bus.Index_w      = w_q[9];
endmodule

// File: tb/tb_name_line_compress.sv
// ---------------------------------------------------------------------------
// tb_name_line_compress
//
// Self-checking bench for name_line_compress. Fields are held as strings in
// the reference model: a field changed when its string differs, its length
// is the string length, and its bus value is the string right-justified.
// Every driven cycle pushes the expected record set into a queue; a monitor
// on the falling edge pops and compares when that expectation falls due.
// ---------------------------------------------------------------------------
module tb_name_line_compress;
    localparam int NF = 10;
`ifdef NLC_REFRESH_EN
    localparam int RP = 4;
`endif

    typedef struct packed {
        int                  due;
        logic [NF-1:0]       w;
        logic [NF-1:0][159:0] o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    name_line_compress_if bus ();

`ifdef NLC_REFRESH_EN
    name_line_compress #(.SEQ_W(16), .REFRESH_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
`else
    name_line_compress #(.SEQ_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
`endif

    // Reference model state
    string cur    [NF];
    string base   [NF];
    string m_prev [NF];
    bit    m_first = 1'b1;
    int    m_seq   = 0;
    exp_t  q[$];

    int n_vec = 0;
    int n_bad = 0;

    string fname [NF] = '{"Inst", "Run", "Flow", "Lane", "Tile",
                          "Xpos", "Ypos_r", "Filtered", "Cntl_num", "Index"};

    function automatic logic [127:0] to_bits(input string s);
        logic [127:0] v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[119:0], s[i]};
        return v;
    endfunction

    function automatic string rand_field();
        string s = "";
        int    n = $urandom_range(0, 16);
        // A small alphabet keeps accidental repeats likely.
        for (int i = 0; i < n; i++) s = {s, string'(8'($urandom_range(65, 70)))};
        return s;
    endfunction

    task automatic check(input string nm, input logic [160:0] act, input logic [160:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus and push the response the model predicts.
    task automatic drive(input bit r, input bit v);
        exp_t         e;
        logic [127:0] vals [NF];
        bit           force_all;
        for (int i = 0; i < NF; i++) vals[i] = to_bits(cur[i]);
        bus.Inst_in     = vals[0];
        bus.Run_in      = vals[1];
        bus.Flow_in     = vals[2];
        bus.Lane_in     = vals[3];
        bus.Tile_in     = vals[4];
        bus.Xpos_in     = vals[5];
        bus.Ypos_r_in   = vals[6];
        bus.Filtered_in = vals[7];
        bus.Cntl_num_in = vals[8];
        bus.Index_in    = vals[9];
        rst             = r;
        bus.line_valid  = v;

        e.due = cyc + 1;
        e.w   = '0;
        e.o   = '0;
        if (r) begin
            m_first = 1'b1;
            m_seq   = 0;
            for (int i = 0; i < NF; i++) m_prev[i] = "";
        end else if (v) begin
            force_all = m_first;
`ifdef NLC_REFRESH_EN
            if (m_seq % RP == 0) force_all = 1'b1;
`endif
            for (int i = 0; i < NF; i++) begin
                if (force_all || cur[i] != m_prev[i]) begin
                    e.w[i] = 1'b1;
                    e.o[i] = {8'(i), 8'(cur[i].len()), 16'(m_seq), vals[i]};
                end
                m_prev[i] = cur[i];
            end
            m_first = 1'b0;
            m_seq   = (m_seq + 1) % 65536;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        logic [NF-1:0]        aw;
        logic [NF-1:0][159:0] ao;
        exp_t                 e;
        aw = {bus.Index_w, bus.Cntl_num_w, bus.Filtered_w, bus.Ypos_r_w, bus.Xpos_w,
              bus.Tile_w, bus.Lane_w, bus.Flow_w, bus.Run_w, bus.Inst_w};
        ao = {bus.Index_out, bus.Cntl_num_out, bus.Filtered_out, bus.Ypos_r_out,
              bus.Xpos_out, bus.Tile_out, bus.Lane_out, bus.Flow_out,
              bus.Run_out, bus.Inst_out};
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            check("stale expectation", 161'(cyc), 161'(e.due));
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            for (int i = 0; i < NF; i++)
                check(fname[i], {aw[i], ao[i]}, {e.w[i], e.o[i]});
        end else if (aw !== '0 && aw !== 'x) begin
            check("unexpected output", 161'(aw), 161'(0));
        end
    end

    initial begin
        base = '{"@HISEQ-MFG", "461", "C70PYACXX", "8", "1101",
                 "18260", "2391 1", "N", "0", "GCCAAT"};
        cur = base;
        for (int i = 0; i < NF; i++) m_prev[i] = "";
        @(posedge clk);
        #1;

        // Reset, then the reference line: everything emitted, seq 0.
        drive(1, 0);
        drive(1, 0);
        drive(0, 1);
        // Only Inst changes.
        cur[0] = "xxx";
        drive(0, 1);
        // Inst restored, Run changed.
        cur[0] = base[0];
        cur[1] = "xxx";
        drive(0, 1);
        // Single-field walk Flow .. Cntl_num.
        for (int f = 2; f <= 8; f++) begin
            cur[f-1] = base[f-1];
            cur[f]   = "xxx";
            drive(0, 1);
        end
        // Every field differs from the previous line; each length 1.
        for (int i = 0; i < NF; i++) cur[i] = "0";
        cur[8] = "9";
        drive(0, 1);
        // Hold three cycles, then a repeat line emits nothing.
        repeat (3) drive(0, 0);
        drive(0, 1);
        // Reset mid-stream with a line presented (discarded), then the same line.
        drive(1, 1);
        drive(0, 1);
        // Identical lines: only a refresh point (if enabled) re-emits.
        repeat (5) drive(0, 1);
        // Empty fields against a prior empty field.
        for (int i = 0; i < NF; i++) cur[i] = "";
        repeat (2) drive(0, 1);

        // Randomized traffic with idles and occasional resets.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NF; i++)
                if ($urandom_range(0, 2) == 0) cur[i] = rand_field();
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
        end

        repeat (3) drive(0, 0);
        @(negedge clk);
        #1;
        check("queue drained", 161'(q.size()), 161'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
